// File: rtl/ball_motion_if.sv
// ball_motion_if
//   Bundles the ball engine's control/hit inputs and its position/status
//   outputs so the block array, bar logic and renderer share one connection.
//   Clock and reset are not part of the bundle; they stay plain ports.
//
//   master : drives start and the OR-collected hit flags, reads ball state
//   slave  : the ball engine itself (ball_motion)
//
//   start                         launch / relaunch request
//   hit_up/down/left/right        OR of all block instance contact flags
//   hit_bar                       ball touching the top of the bar
//   x_ball, y_ball                registered ball centre
//   next_x, next_y                position after the next motion tick
//   dir_x, dir_y                  direction, 1 = +x / +y (right / down)
//   moving, lost, tick            status and motion-update strobe
interface ball_motion_if;
    logic       start;
    logic       hit_up;
    logic       hit_down;
    logic       hit_left;
    logic       hit_right;
    logic       hit_bar;
    logic [9:0] x_ball;
    logic [9:0] y_ball;
    logic [9:0] next_x;
    logic [9:0] next_y;
    logic       dir_x;
    logic       dir_y;
    logic       moving;
    logic       lost;
    logic       tick;

    modport master (
        output start, hit_up, hit_down, hit_left, hit_right, hit_bar,
        input  x_ball, y_ball, next_x, next_y, dir_x, dir_y, moving, lost, tick
    );

    modport slave (
        input  start, hit_up, hit_down, hit_left, hit_right, hit_bar,
        output x_ball, y_ball, next_x, next_y, dir_x, dir_y, moving, lost, tick
    );
endinterface

// File: rtl/ball_motion.sv
// ball_motion
//   Ball position engine for the Breakout datapath. Collects block/bar hit
//   flags into a sticky register between motion ticks, resolves the ball
//   direction against the playfield walls and the collected hits at each
//   tick, and steps the ball by STEP pixels per axis. A ball that reaches the
//   bottom band is declared lost and frozen until the next start.
//
//   Ports:
//     clock  : single clock, all state on its rising edge
//     reset  : synchronous, active-high
//     bus    : ball_motion_if.slave (start, hit flags in; position, next
//              position, direction, moving, lost, tick out)
//
//   Parameters: R_BALL, STEP (1..R_BALL), X0, Y0, TICK_DIV (>= 2), TICK_MIN.
//
//   Build option BALL_SPEEDUP_EN: when defined, every eighth tick that
//   consumed a block hit halves the tick period, floored at TICK_MIN. When
//   undefined the period is the constant TICK_DIV.
module ball_motion #(
    parameter int R_BALL   = 8,
    parameter int STEP     = 1,
    parameter int X0       = 320,
    parameter int Y0       = 400,
    parameter int TICK_DIV = 250000,
    parameter int TICK_MIN = 62500
) (
    input  logic         clock,
    input  logic         reset,
    ball_motion_if.slave bus
);

    // Counter width covers both period bounds so floor comparisons never truncate.
    localparam int DIV_MAX = (TICK_DIV > TICK_MIN) ? TICK_DIV : TICK_MIN;
    localparam int DIV_W   = $clog2(DIV_MAX + 1);

    localparam logic [DIV_W-1:0] DIV_INIT = DIV_W'(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [9:0]       X0_V     = 10'(X0);
    localparam logic [9:0]       Y0_V     = 10'(Y0);
    localparam logic [9:0]       R_V      = 10'(R_BALL);
    localparam logic [9:0]       STEP_V   = 10'(STEP);
    localparam logic [9:0]       X_WALL   = 10'(640 - R_BALL);
    localparam logic [9:0]       Y_LOSS   = 10'(480 - R_BALL);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LOST = 2'd2
    } state_t;

    state_t           state_r;
    logic [9:0]       x_r;
    logic [9:0]       y_r;
    logic             dir_x_r;
    logic             dir_y_r;
    logic             moving_r;
    logic             lost_r;
    logic             tick_r;
    logic [DIV_W-1:0] cnt_r;
    logic [DIV_W-1:0] cnt_inc_s;
    logic [DIV_W-1:0] div_s;

    // Hit vector layout: {up, down, left, right, bar}
    logic [4:0]       sticky_r;
    logic [4:0]       hits_s;
    logic [4:0]       eff_s;
    logic             hit_l_s;
    logic             hit_r_s;
    logic             hit_u_s;
    logic             hit_d_s;

    logic             dir_x_res_s;
    logic             dir_y_res_s;
    logic             loss_s;
    logic [9:0]       step_x_s;
    logic [9:0]       step_y_s;
    logic [9:0]       next_x_s;
    logic [9:0]       next_y_s;

`ifdef BALL_SPEEDUP_EN
    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(TICK_MIN);

    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] div_half_s;
    logic [DIV_W-1:0] div_dec_s;
    logic [2:0]       hit_cnt_r;
    logic             block_hit_s;

    // Halved tick period, clamped to the floor
    always_comb begin
        div_half_s = {1'b0, div_r[DIV_W-1:1]};
        if (div_half_s < DIV_MIN) begin
            div_dec_s = DIV_MIN;
        end else begin
            div_dec_s = div_half_s;
        end
    end

    assign div_s       = div_r;
    // The bar does not count towards speedup, only block contacts do.
    assign block_hit_s = |eff_s[4:1];
`else
    assign div_s = DIV_INIT;
`endif

    assign hits_s    = {bus.hit_up, bus.hit_down, bus.hit_left, bus.hit_right, bus.hit_bar};
    assign cnt_inc_s = cnt_r + DIV_ONE;

    // Direction resolution and step; live flags are folded in so a hit in the
    // tick cycle itself is consumed by that tick and next_x/next_y agree with it.
    always_comb begin
        eff_s   = sticky_r | hits_s;
        hit_u_s = eff_s[4] | eff_s[0];
        hit_d_s = eff_s[3];
        hit_l_s = eff_s[2];
        hit_r_s = eff_s[1];

        if (x_r <= R_V) begin
            dir_x_res_s = 1'b1;
        end else if (x_r >= X_WALL) begin
            dir_x_res_s = 1'b0;
        end else if (hit_l_s && hit_r_s) begin
            dir_x_res_s = ~dir_x_r;
        end else if (hit_l_s) begin
            dir_x_res_s = 1'b0;
        end else if (hit_r_s) begin
            dir_x_res_s = 1'b1;
        end else begin
            dir_x_res_s = dir_x_r;
        end

        // Only the top edge is a wall on y; the bottom band is the loss zone.
        if (y_r <= R_V) begin
            dir_y_res_s = 1'b1;
        end else if (hit_u_s && hit_d_s) begin
            dir_y_res_s = ~dir_y_r;
        end else if (hit_u_s) begin
            dir_y_res_s = 1'b0;
        end else if (hit_d_s) begin
            dir_y_res_s = 1'b1;
        end else begin
            dir_y_res_s = dir_y_r;
        end

        if (dir_x_res_s) begin
            step_x_s = x_r + STEP_V;
        end else begin
            step_x_s = x_r - STEP_V;
        end

        if (dir_y_res_s) begin
            step_y_s = y_r + STEP_V;
        end else begin
            step_y_s = y_r - STEP_V;
        end

        loss_s = (y_r >= Y_LOSS);

        if (state_r == RUN) begin
            next_x_s = step_x_s;
            next_y_s = step_y_s;
        end else begin
            next_x_s = x_r;
            next_y_s = y_r;
        end
    end

    // Game FSM, tick divider, sticky hits and ball position
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= IDLE;
            x_r       <= X0_V;
            y_r       <= Y0_V;
            dir_x_r   <= 1'b1;
            dir_y_r   <= 1'b0;
            moving_r  <= 1'b0;
            lost_r    <= 1'b0;
            tick_r    <= 1'b0;
            cnt_r     <= {DIV_W{1'b0}};
            sticky_r  <= 5'b00000;
`ifdef BALL_SPEEDUP_EN
            div_r     <= DIV_INIT;
            hit_cnt_r <= 3'd0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        state_r  <= RUN;
                        moving_r <= 1'b1;
                        cnt_r    <= {DIV_W{1'b0}};
                        tick_r   <= 1'b0;
                        sticky_r <= 5'b00000;
                    end
                end
                RUN: begin
                    if (tick_r) begin
                        cnt_r    <= {DIV_W{1'b0}};
                        tick_r   <= 1'b0;
                        sticky_r <= 5'b00000;
                        if (loss_s) begin
                            state_r  <= LOST;
                            moving_r <= 1'b0;
                            lost_r   <= 1'b1;
                        end else begin
                            x_r     <= step_x_s;
                            y_r     <= step_y_s;
                            dir_x_r <= dir_x_res_s;
                            dir_y_r <= dir_y_res_s;
                        end
`ifdef BALL_SPEEDUP_EN
                        if (block_hit_s) begin
                            hit_cnt_r <= hit_cnt_r + 3'd1;
                            if (hit_cnt_r == 3'd7) begin
                                div_r <= div_dec_s;
                            end
                        end
`endif
                    end else begin
                        // tick is registered: raise it for the cycle whose count is div-1
                        cnt_r    <= cnt_inc_s;
                        tick_r   <= (cnt_inc_s == (div_s - DIV_ONE));
                        sticky_r <= eff_s;
                    end
                end
                LOST: begin
                    if (bus.start) begin
                        state_r   <= RUN;
                        x_r       <= X0_V;
                        y_r       <= Y0_V;
                        dir_x_r   <= 1'b1;
                        dir_y_r   <= 1'b0;
                        moving_r  <= 1'b1;
                        lost_r    <= 1'b0;
                        tick_r    <= 1'b0;
                        cnt_r     <= {DIV_W{1'b0}};
                        sticky_r  <= 5'b00000;
`ifdef BALL_SPEEDUP_EN
                        div_r     <= DIV_INIT;
                        hit_cnt_r <= 3'd0;
`endif
                    end
                end
                default: begin
                    state_r  <= IDLE;
                    moving_r <= 1'b0;
                    lost_r   <= 1'b0;
                    tick_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.x_ball = x_r;
    assign bus.y_ball = y_r;
    assign bus.next_x = next_x_s;
    assign bus.next_y = next_y_s;
    assign bus.dir_x  = dir_x_r;
    assign bus.dir_y  = dir_y_r;
    assign bus.moving = moving_r;
    assign bus.lost   = lost_r;
    assign bus.tick   = tick_r;

endmodule

// File: tb/tb_ball_motion.sv
// tb_ball_motion
//   Self-checking bench for ball_motion with TICK_DIV=4, R_BALL=8, STEP=1,
//   TICK_MIN=2. Expected post-tick states are queued before each interval is
//   driven and compared when the DUT raises tick.
module tb_ball_motion;

    logic clock = 1'b0;
    logic reset = 1'b1;

    ball_motion_if bus();

    ball_motion #(
        .R_BALL  (8),
        .STEP    (1),
        .X0      (320),
        .Y0      (400),
        .TICK_DIV(4),
        .TICK_MIN(2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [9:0] x;
        logic [9:0] y;
        logic       dx;
        logic       dy;
        logic       lost;
    } exp_t;

    // hits layout: {up, down, left, right, bar}
    typedef struct {
        logic [4:0] hits;
        int         x;
        int         y;
        logic       dx;
        logic       dy;
    } vec_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    logic pending = 1'b0;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    function automatic exp_t mk(input int x, input int y, input logic dx,
                                input logic dy, input logic lost);
        exp_t e;
        e.x    = x[9:0];
        e.y    = y[9:0];
        e.dx   = dx;
        e.dy   = dy;
        e.lost = lost;
        return e;
    endfunction

    // Scoreboard: compare the state registered on each tick edge
    always @(negedge clock) begin
        if (pending) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_tick", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_x", bus.x_ball, e.x);
                check("sb_y", bus.y_ball, e.y);
                check("sb_dir_x", bus.dir_x, e.dx);
                check("sb_dir_y", bus.dir_y, e.dy);
                check("sb_lost", bus.lost, e.lost);
            end
        end
        pending <= bus.tick;
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [4:0] h);
        bus.hit_up    = h[4];
        bus.hit_down  = h[3];
        bus.hit_left  = h[2];
        bus.hit_right = h[1];
        bus.hit_bar   = h[0];
    endtask

    // Wait (bounded) for the tick cycle, then step over the tick edge
    task automatic wait_tick();
        int n;
        n = 0;
        while (bus.tick !== 1'b1 && n < 16) begin
            cyc();
            n++;
        end
        if (bus.tick !== 1'b1) begin
            check("tick_timeout", 0, 1);
        end
        cyc();
    endtask

    // One motion interval starting right after a tick/launch edge:
    // one-cycle hit pulse mid-interval, optional next_x/next_y check, tick.
    task automatic do_interval(input logic [4:0] h, input exp_t e, input bit chk_next);
        exp_q.push_back(e);
        cyc();
        drive(h);
        cyc();
        drive(5'b00000);
        if (chk_next) begin
            check("next_x", bus.next_x, e.x);
            check("next_y", bus.next_y, e.y);
        end
        wait_tick();
    endtask

    task automatic launch();
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        check("launch_moving", bus.moving, 1);
        check("launch_lost", bus.lost, 0);
        check("launch_x", bus.x_ball, 320);
        check("launch_y", bus.y_ball, 400);
        check("launch_dir_x", bus.dir_x, 1);
        check("launch_dir_y", bus.dir_y, 0);
    endtask

    initial begin
        vec_t vecs[8];
        int   ex;
        int   ey;
        int   n;

        vecs[0] = '{5'b00000, 321, 399, 1'b1, 1'b0};  // plain launch tick
        vecs[1] = '{5'b10000, 322, 398, 1'b1, 1'b0};  // hit_up while going up
        vecs[2] = '{5'b01000, 323, 399, 1'b1, 1'b1};  // hit_down flips to down
        vecs[3] = '{5'b00110, 322, 400, 1'b0, 1'b1};  // left+right inverts dir_x
        vecs[4] = '{5'b00001, 321, 399, 1'b0, 1'b0};  // bar sends ball up
        vecs[5] = '{5'b00010, 322, 398, 1'b1, 1'b0};  // hit_right
        vecs[6] = '{5'b11000, 323, 399, 1'b1, 1'b1};  // up+down inverts dir_y
        vecs[7] = '{5'b01001, 324, 398, 1'b1, 1'b0};  // bar+down inverts dir_y

        bus.start = 1'b0;
        drive(5'b00000);
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        cyc();
        cyc();

        check("rst_x", bus.x_ball, 320);
        check("rst_y", bus.y_ball, 400);
        check("rst_dir_x", bus.dir_x, 1);
        check("rst_dir_y", bus.dir_y, 0);
        check("rst_moving", bus.moving, 0);
        check("rst_lost", bus.lost, 0);
        check("rst_tick", bus.tick, 0);
        check("idle_next_x", bus.next_x, 320);
        check("idle_next_y", bus.next_y, 400);

        launch();
        for (int i = 0; i < 8; i++) begin
            do_interval(vecs[i].hits, mk(vecs[i].x, vecs[i].y, vecs[i].dx, vecs[i].dy, 1'b0), 1'b1);
        end

        // Steer to the top-left corner: up-right until x==y, then up-left.
        ex = 324;
        ey = 398;
        for (int i = 0; i < 37; i++) begin
            ex++;
            ey--;
            do_interval(5'b00000, mk(ex, ey, 1'b1, 1'b0, 1'b0), 1'b1);
        end
        ex--;
        ey--;
        do_interval(5'b00100, mk(ex, ey, 1'b0, 1'b0, 1'b0), 1'b1);
        for (int i = 0; i < 352; i++) begin
            ex--;
            ey--;
            do_interval(5'b00000, mk(ex, ey, 1'b0, 1'b0, 1'b0), 1'b1);
        end
        check("corner_pre_x", bus.x_ball, 8);
        check("corner_pre_y", bus.y_ball, 8);
        do_interval(5'b00000, mk(9, 9, 1'b1, 1'b1, 1'b0), 1'b1);

        // Fall down-right to the loss band.
        ex = 9;
        ey = 9;
        while (ey < 472) begin
            ex++;
            ey++;
            do_interval(5'b00000, mk(ex, ey, 1'b1, 1'b1, 1'b0), 1'b1);
        end
        do_interval(5'b00000, mk(472, 472, 1'b1, 1'b1, 1'b1), 1'b0);
        cyc();
        cyc();
        cyc();
        check("lost_flag", bus.lost, 1);
        check("lost_moving", bus.moving, 0);
        check("lost_x_frozen", bus.x_ball, 472);
        check("lost_y_frozen", bus.y_ball, 472);
        check("lost_next_x", bus.next_x, 472);
        check("lost_next_y", bus.next_y, 472);

        launch();
        do_interval(5'b00000, mk(321, 399, 1'b1, 1'b0, 1'b0), 1'b1);

        // Reset coincident with the tick edge wins over the move.
        exp_q.push_back(mk(320, 400, 1'b1, 1'b0, 1'b0));
        cyc();
        cyc();
        cyc();
        check("tick_before_reset", bus.tick, 1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("rst_tick_x", bus.x_ball, 320);
        check("rst_tick_y", bus.y_ball, 400);
        check("rst_tick_moving", bus.moving, 0);
        check("rst_tick_tick", bus.tick, 0);
        check("rst_tick_lost", bus.lost, 0);
        check("rst_tick_dir_x", bus.dir_x, 1);
        check("rst_tick_dir_y", bus.dir_y, 0);

        n = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (bus.tick === 1'b1) n++;
        end
        check("idle_no_tick", n, 0);
        check("idle_hold_x", bus.x_ball, 320);

        // Eight block-hit ticks, then measure the tick period.
        launch();
        for (int i = 1; i <= 8; i++) begin
            do_interval(5'b10000, mk(320 + i, 400 - i, 1'b1, 1'b0, 1'b0), 1'b1);
        end
        exp_q.push_back(mk(329, 391, 1'b1, 1'b0, 1'b0));
        n = 0;
        while (bus.tick !== 1'b1 && n < 16) begin
            cyc();
            n++;
        end
`ifdef BALL_SPEEDUP_EN
        check("tick_period", n + 1, 2);
`else
        check("tick_period", n + 1, 4);
`endif
        cyc();
        cyc();
        cyc();
        check("sb_leftover", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
